rsr_wakeup_scoreboard: RTL and testbench

//  Receiving end of the RSR tag broadcast. Holds one ready bit per physical register.
//  - Set by tags broadcast from every lane's RSR head.
//  - Cleared when rename allocates the register as a destination.
//  - Answers dispatch source-readiness queries, with same-cycle broadcast bypass and

---
 rtl/rsr_wakeup_scoreboard_if.sv | 30 +++
 rtl/rsr_wakeup_scoreboard.sv | 130 +++++++++++++
 tb/tb_rsr_wakeup_scoreboard.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rsr_wakeup_scoreboard_if.sv
// Port bundle between the RSR tag broadcast, rename/dispatch and the wakeup scoreboard.
// The bundle width follows the SIZE_PHYSICAL_LOG macro, which defaults to 6 (64 registers).
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 6
`endif

interface rsr_sb_if #(
  parameter int NUM_LANES      = 5,
  parameter int DISPATCH_WIDTH = 4,
  parameter int PHYS_LOG       = `SIZE_PHYSICAL_LOG
);
  // Each entry is {valid, reg_id}.
  logic [NUM_LANES-1:0][PHYS_LOG:0]        rsrTag_i;
  logic [DISPATCH_WIDTH-1:0][PHYS_LOG:0]   allocDest_i;
  logic [2*DISPATCH_WIDTH-1:0][PHYS_LOG:0] srcQuery_i;
  logic [2*DISPATCH_WIDTH-1:0]             srcReady_o;
  logic                                    recover_i;
  logic [PHYS_LOG:0]                       pendingCnt_o;
  logic                                    sbError_o;

  modport master (
    output rsrTag_i, allocDest_i, srcQuery_i, recover_i,
    input  srcReady_o, pendingCnt_o, sbError_o
  );

  modport slave (
    input  rsrTag_i, allocDest_i, srcQuery_i, recover_i,
    output srcReady_o, pendingCnt_o, sbError_o
  );
endinterface

// File: rtl/rsr_wakeup_scoreboard.sv
// Per-physical-register ready scoreboard with same-cycle tag bypass and intra-group dependency check.
// Optional protocol checker enabled by defining RSR_SB_CHECK_EN; otherwise sbError_o is tied to 0.
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 6
`endif

module rsr_wakeup_scoreboard #(
  parameter int NUM_LANES      = 5,
  parameter int DISPATCH_WIDTH = 4,
  parameter int PHYS_LOG       = `SIZE_PHYSICAL_LOG
) (
  input  logic    clk,
  input  logic    reset,
  rsr_sb_if.slave sb
);
  localparam int PHYS_REGS = 1 << PHYS_LOG;
  localparam int NUM_SRC   = 2 * DISPATCH_WIDTH;

  typedef logic [PHYS_LOG-1:0] id_t;
  typedef logic [PHYS_LOG:0]   cnt_t;
  typedef logic [PHYS_LOG+1:0] sum_t;

  logic [PHYS_REGS-1:0] ready_q, ready_d;
  logic [PHYS_REGS-1:0] alloc_hit, tag_hit;
  logic [PHYS_REGS-1:0] clr_vec, set_vec;
  cnt_t                 cnt_q, cnt_d;
  sum_t                 clr_cnt, set_cnt, cnt_up, cnt_net;

  logic [NUM_SRC-1:0]   src_ready;
  logic                 older_dep;
  id_t                  qid;

  always_comb begin
    alloc_hit = '0;
    tag_hit   = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      if (sb.allocDest_i[k][PHYS_LOG]) alloc_hit[sb.allocDest_i[k][PHYS_LOG-1:0]] = 1'b1;
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      if (sb.rsrTag_i[l][PHYS_LOG]) tag_hit[sb.rsrTag_i[l][PHYS_LOG-1:0]] = 1'b1;
    end
  end

  // Alloc wins over a same-cycle tag; recovery wins over both.
  always_comb begin
    if (sb.recover_i) ready_d = '1;
    else              ready_d = (ready_q | tag_hit) & ~alloc_hit;

    clr_vec = ready_q & ~ready_d;
    set_vec = ~ready_q & ready_d;
    clr_cnt = '0;
    set_cnt = '0;
    for (int r = 0; r < PHYS_REGS; r++) begin
      clr_cnt = clr_cnt + sum_t'(clr_vec[r]);
      set_cnt = set_cnt + sum_t'(set_vec[r]);
    end

    cnt_up  = sum_t'(cnt_q) + clr_cnt;
    cnt_net = '0;
    if (cnt_up > set_cnt) cnt_net = cnt_up - set_cnt;

    if (sb.recover_i)                    cnt_d = '0;
    else if (cnt_net > sum_t'(PHYS_REGS)) cnt_d = cnt_t'(PHYS_REGS);
    else                                  cnt_d = cnt_t'(cnt_net);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= '1;
      cnt_q   <= '0;
    end else begin
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only older slots of the group create a dependency; own and younger allocs are invisible.
  always_comb begin
    src_ready = '1;
    older_dep = 1'b0;
    qid       = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      older_dep = 1'b0;
      qid       = sb.srcQuery_i[s][PHYS_LOG-1:0];
      if (sb.srcQuery_i[s][PHYS_LOG]) begin
        for (int j = 0; j < DISPATCH_WIDTH; j++) begin
          if ((j < s / 2) && sb.allocDest_i[j][PHYS_LOG] &&
              (sb.allocDest_i[j][PHYS_LOG-1:0] == qid)) older_dep = 1'b1;
        end
        src_ready[s] = !older_dep && (ready_q[qid] || tag_hit[qid]);
      end
    end
  end

  assign sb.srcReady_o   = src_ready;
  assign sb.pendingCnt_o = cnt_q;

`ifdef RSR_SB_CHECK_EN
  logic err_q, err_d, viol;

  always_comb begin
    viol = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (sb.rsrTag_i[l][PHYS_LOG] && ready_q[sb.rsrTag_i[l][PHYS_LOG-1:0]]) viol = 1'b1;
      for (int m = l + 1; m < NUM_LANES; m++) begin
        if (sb.rsrTag_i[l][PHYS_LOG] && sb.rsrTag_i[m][PHYS_LOG] &&
            (sb.rsrTag_i[l][PHYS_LOG-1:0] == sb.rsrTag_i[m][PHYS_LOG-1:0])) viol = 1'b1;
      end
    end
    if (|(alloc_hit & tag_hit)) viol = 1'b1;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      for (int n = k + 1; n < DISPATCH_WIDTH; n++) begin
        if (sb.allocDest_i[k][PHYS_LOG] && sb.allocDest_i[n][PHYS_LOG] &&
            (sb.allocDest_i[k][PHYS_LOG-1:0] == sb.allocDest_i[n][PHYS_LOG-1:0])) viol = 1'b1;
      end
    end
    err_d = err_q | (viol & ~sb.recover_i);
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign sb.sbError_o = err_q;
`else
  assign sb.sbError_o = 1'b0;
`endif

endmodule

// File: tb/tb_rsr_wakeup_scoreboard.sv
// Directed and random checks of the wakeup scoreboard against a per-register behavioural model.
// Honours RSR_SB_CHECK_EN for the expected sbError_o.
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 6
`endif

module tb_rsr_wakeup_scoreboard;
  localparam int LOG   = `SIZE_PHYSICAL_LOG;
  localparam int NREG  = 1 << LOG;
  localparam int LANES = 5;
  localparam int DW    = 4;
  localparam int NSRC  = 2 * DW;
`ifdef RSR_SB_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rsr_sb_if #(.NUM_LANES(LANES), .DISPATCH_WIDTH(DW), .PHYS_LOG(LOG)) sb_if ();

  rsr_wakeup_scoreboard #(.NUM_LANES(LANES), .DISPATCH_WIDTH(DW), .PHYS_LOG(LOG)) dut (
    .clk  (clk),
    .reset(reset),
    .sb   (sb_if)
  );

  int errors = 0;
  int checks = 0;
  bit m_ready [NREG];
  bit m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr();
    sb_if.rsrTag_i    = '0;
    sb_if.allocDest_i = '0;
    sb_if.srcQuery_i  = '0;
    sb_if.recover_i   = 1'b0;
  endtask

  task automatic set_tag(input int l, input int id);
    logic [31:0] v = id;
    sb_if.rsrTag_i[l] = {1'b1, v[LOG-1:0]};
  endtask

  task automatic set_alloc(input int k, input int id);
    logic [31:0] v = id;
    sb_if.allocDest_i[k] = {1'b1, v[LOG-1:0]};
  endtask

  task automatic set_query(input int s, input int id);
    logic [31:0] v = id;
    sb_if.srcQuery_i[s] = {1'b1, v[LOG-1:0]};
  endtask

  function automatic int tag_id(input int l);
    return sb_if.rsrTag_i[l][LOG] ? int'(sb_if.rsrTag_i[l][LOG-1:0]) : -1;
  endfunction

  function automatic int alloc_id(input int k);
    return sb_if.allocDest_i[k][LOG] ? int'(sb_if.allocDest_i[k][LOG-1:0]) : -1;
  endfunction

  function automatic logic [NSRC-1:0] exp_ready();
    logic [NSRC-1:0] e;
    for (int s = 0; s < NSRC; s++) begin
      int id;
      bit dep, byp;
      e[s] = 1'b1;
      if (sb_if.srcQuery_i[s][LOG]) begin
        id  = int'(sb_if.srcQuery_i[s][LOG-1:0]);
        dep = 0;
        byp = 0;
        for (int j = 0; j < s / 2; j++) if (alloc_id(j) == id) dep = 1;
        for (int l = 0; l < LANES; l++) if (tag_id(l) == id) byp = 1;
        e[s] = dep ? 1'b0 : (m_ready[id] | byp);
      end
    end
    return e;
  endfunction

  function automatic int pending();
    int c = 0;
    for (int r = 0; r < NREG; r++) if (!m_ready[r]) c++;
    return c;
  endfunction

  task automatic model_update();
    bit nr [NREG];
    bit viol;
    if (reset) begin
      foreach (m_ready[r]) m_ready[r] = 1'b1;
      m_err = 1'b0;
      return;
    end
    if (CHK && !sb_if.recover_i) begin
      viol = 0;
      for (int l = 0; l < LANES; l++) begin
        if (tag_id(l) >= 0 && m_ready[tag_id(l)]) viol = 1;
        for (int m = l + 1; m < LANES; m++) if (tag_id(l) >= 0 && tag_id(l) == tag_id(m)) viol = 1;
        for (int k = 0; k < DW; k++) if (tag_id(l) >= 0 && tag_id(l) == alloc_id(k)) viol = 1;
      end
      for (int k = 0; k < DW; k++)
        for (int n = k + 1; n < DW; n++) if (alloc_id(k) >= 0 && alloc_id(k) == alloc_id(n)) viol = 1;
      m_err = m_err | viol;
    end
    if (sb_if.recover_i) begin
      foreach (m_ready[r]) m_ready[r] = 1'b1;
    end else begin
      nr = m_ready;
      for (int l = 0; l < LANES; l++) if (tag_id(l) >= 0) nr[tag_id(l)] = 1'b1;
      for (int k = 0; k < DW; k++) if (alloc_id(k) >= 0) nr[alloc_id(k)] = 1'b0;
      m_ready = nr;
    end
  endtask

  // Outputs are sampled on the falling edge, mid-cycle, after inputs settle.
  task automatic step();
    @(negedge clk);
    chk("srcReady", 32'(sb_if.srcReady_o), 32'(exp_ready()));
    chk("pendingCnt", 32'(sb_if.pendingCnt_o), 32'(pending()));
    chk("sbError", 32'(sb_if.sbError_o), 32'(m_err));
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc();
    step();
    adv();
  endtask

  initial begin
    reset = 1'b1;
    clr();
    adv();
    adv();
    reset = 1'b0;

    for (int i = 0; i < 8; i++) set_query(i, i);
    step();
    chk("lit_reset_ready", 32'(sb_if.srcReady_o), 32'hFF);
    chk("lit_reset_cnt", 32'(sb_if.pendingCnt_o), 0);
    adv();

    clr(); set_alloc(0, 10); cyc();
    clr(); set_query(0, 10); step();
    chk("lit_alloc10_q", 32'(sb_if.srcReady_o[0]), 0);
    chk("lit_alloc10_cnt", 32'(sb_if.pendingCnt_o), 1);
    adv();
    clr(); cyc();
    clr(); set_tag(2, 10); set_query(0, 10); step();
    chk("lit_bypass10", 32'(sb_if.srcReady_o[0]), 1);
    adv();
    clr(); set_query(0, 10); step();
    chk("lit_set10_q", 32'(sb_if.srcReady_o[0]), 1);
    chk("lit_set10_cnt", 32'(sb_if.pendingCnt_o), 0);
    adv();

    clr(); set_alloc(0, 20); set_query(2, 20); set_query(0, 20); step();
    chk("lit_grp_dep", 32'(sb_if.srcReady_o[2]), 0);
    chk("lit_grp_own", 32'(sb_if.srcReady_o[0]), 1);
    adv();
    clr(); set_tag(0, 20); cyc();
    clr(); set_alloc(1, 21); set_query(3, 21); set_query(4, 21); set_query(1, 21); step();
    chk("lit_grp_ownslot", 32'(sb_if.srcReady_o[3]), 1);
    chk("lit_grp_older", 32'(sb_if.srcReady_o[4]), 0);
    chk("lit_grp_younger", 32'(sb_if.srcReady_o[1]), 1);
    adv();
    clr(); set_tag(4, 21); cyc();

    clr(); set_alloc(0, 30); set_alloc(1, 31); set_alloc(2, 32); cyc();
    clr(); step();
    chk("lit_three_cnt", 32'(sb_if.pendingCnt_o), 3);
    adv();
    clr(); sb_if.recover_i = 1'b1; set_tag(0, 30); set_alloc(0, 33); cyc();
    clr(); for (int i = 0; i < 4; i++) set_query(i, 30 + i); step();
    chk("lit_recover_ready", 32'(sb_if.srcReady_o[3:0]), 32'hF);
    chk("lit_recover_cnt", 32'(sb_if.pendingCnt_o), 0);
    chk("lit_recover_noerr", 32'(sb_if.sbError_o), 0);
    adv();

    clr(); set_alloc(0, 40); set_tag(1, 40); cyc();
    clr(); set_query(0, 40); step();
    chk("lit_alloc_wins", 32'(sb_if.srcReady_o[0]), 0);
    chk("lit_alloc_wins_cnt", 32'(sb_if.pendingCnt_o), 1);
    chk("lit_err_c", 32'(sb_if.sbError_o), 32'(CHK));
    adv();

    clr(); set_alloc(0, 50); cyc();
    clr(); set_tag(0, 50); set_tag(3, 50); step();
    chk("lit_dup_pre_cnt", 32'(sb_if.pendingCnt_o), 2);
    adv();
    clr(); step();
    chk("lit_dup_tag_cnt", 32'(sb_if.pendingCnt_o), 1);
    chk("lit_err_sticky", 32'(sb_if.sbError_o), 32'(CHK));
    adv();

    clr(); sb_if.recover_i = 1'b1; cyc();
    clr(); step();
    chk("lit_recover_keeps_err", 32'(sb_if.sbError_o), 32'(CHK));
    adv();

    clr(); set_alloc(0, 60); reset = 1'b1; cyc();
    reset = 1'b0;
    clr(); set_query(0, 60); step();
    chk("lit_reset_cnt2", 32'(sb_if.pendingCnt_o), 0);
    chk("lit_reset_err", 32'(sb_if.sbError_o), 0);
    chk("lit_reset_q60", 32'(sb_if.srcReady_o[0]), 1);
    adv();

    for (int n = 0; n < 3000; n++) begin
      int hi;
      clr();
      hi = ($urandom_range(0, 9) == 0) ? NREG - 1 : 15;
      reset = ($urandom_range(0, 299) == 0);
      sb_if.recover_i = ($urandom_range(0, 59) == 0);
      for (int l = 0; l < LANES; l++)
        if ($urandom_range(0, 9) < 3) set_tag(l, $urandom_range(0, hi));
      for (int k = 0; k < DW; k++)
        if ($urandom_range(0, 9) < 4) set_alloc(k, $urandom_range(0, hi));
      for (int s = 0; s < NSRC; s++)
        if ($urandom_range(0, 9) < 8) set_query(s, $urandom_range(0, hi));
      cyc();
    end
    reset = 1'b0;
    clr();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
